// File: rtl/sprite_compositor.sv
// Composites NUM_SPR solid-colour rectangular sprites over a bordered background.
// Double-banked attributes (pending -> active on frame_start), 2-cycle pixel pipeline, per-frame collision flag.
module sprite_compositor #(
    parameter int unsigned NUM_SPR = 4,
    parameter int unsigned IDXW    = 2,
    parameter int unsigned SPR_W   = 32,
    parameter int unsigned SPR_H   = 32,
    parameter int unsigned SCR_W   = 1280,
    parameter int unsigned SCR_H   = 800,
    parameter int unsigned BORDER  = 11,
    parameter logic [11:0] BG_RGB  = 12'h060,
    parameter logic [11:0] BRD_RGB = 12'hFFF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [10:0]     draw_x,
    input  logic [9:0]      draw_y,
    input  logic            pix_valid,
    input  logic            frame_start,
    input  logic            wr_en,
    input  logic [IDXW-1:0] wr_idx,
    input  logic [10:0]     wr_x,
    input  logic [9:0]      wr_y,
    input  logic [11:0]     wr_rgb,
    input  logic            wr_vis,
    output logic [3:0]      r,
    output logic [3:0]      g,
    output logic [3:0]      b,
    output logic            out_valid,
    output logic            hit_any,
    output logic [IDXW-1:0] hit_idx,
    output logic            collide
);

    logic [10:0] pend_x   [NUM_SPR];
    logic [9:0]  pend_y   [NUM_SPR];
    logic [11:0] pend_rgb [NUM_SPR];
    logic        pend_vis [NUM_SPR];
    logic [10:0] act_x    [NUM_SPR];
    logic [9:0]  act_y    [NUM_SPR];
    logic [11:0] act_rgb  [NUM_SPR];
    logic        act_vis  [NUM_SPR];

    logic [NUM_SPR-1:0] hit_c;
    logic               border_c;
    logic [NUM_SPR-1:0] hit_s1;
    logic               border_s1;
    logic               valid_s1;

    logic               win_any;
    logic [IDXW-1:0]    win_idx;
    logic [11:0]        win_rgb;
    logic [11:0]        pix_rgb;
    logic               multi_hit;
    logic               coll_acc;

    // Active bank copies pending before this cycle's write lands, so a write
    // coincident with frame_start shows up one frame later.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_SPR; i++) begin
                pend_x[i]   <= '0;
                pend_y[i]   <= '0;
                pend_rgb[i] <= '0;
                pend_vis[i] <= 1'b0;
                act_x[i]    <= '0;
                act_y[i]    <= '0;
                act_rgb[i]  <= '0;
                act_vis[i]  <= 1'b0;
            end
        end else begin
            if (frame_start) begin
                for (int unsigned i = 0; i < NUM_SPR; i++) begin
                    act_x[i]   <= pend_x[i];
                    act_y[i]   <= pend_y[i];
                    act_rgb[i] <= pend_rgb[i];
                    act_vis[i] <= pend_vis[i];
                end
            end
            if (wr_en && (32'(wr_idx) < NUM_SPR)) begin
                pend_x[wr_idx]   <= wr_x;
                pend_y[wr_idx]   <= wr_y;
                pend_rgb[wr_idx] <= wr_rgb;
                pend_vis[wr_idx] <= wr_vis;
            end
        end
    end

    // Bounds widened by one bit so sprites at the right/bottom edge never wrap.
    always_comb begin
        hit_c = '0;
        for (int unsigned i = 0; i < NUM_SPR; i++) begin
            if (act_vis[i]
                && ({1'b0, draw_x} >= {1'b0, act_x[i]})
                && ({1'b0, draw_x} <= ({1'b0, act_x[i]} + 12'(SPR_W - 1)))
                && ({1'b0, draw_y} >= {1'b0, act_y[i]})
                && ({1'b0, draw_y} <= ({1'b0, act_y[i]} + 11'(SPR_H - 1)))) begin
                hit_c[i] = 1'b1;
            end
        end
    end

    always_comb begin
        border_c = (draw_x < 11'(BORDER)) || (draw_x >= 11'(SCR_W - BORDER))
                || (draw_y < 10'(BORDER)) || (draw_y >= 10'(SCR_H - BORDER));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_s1    <= '0;
            border_s1 <= 1'b0;
            valid_s1  <= 1'b0;
        end else begin
            hit_s1    <= hit_c;
            border_s1 <= border_c;
            valid_s1  <= pix_valid;
        end
    end

    always_comb begin
        win_any = 1'b0;
        win_idx = '0;
        win_rgb = '0;
        for (int unsigned i = 0; i < NUM_SPR; i++) begin
            if (hit_s1[i] && !win_any) begin
                win_any = 1'b1;
                win_idx = IDXW'(i);
                win_rgb = act_rgb[i];
            end
        end
    end

    always_comb begin
        if (win_any) begin
            pix_rgb = win_rgb;
        end else if (border_s1) begin
            pix_rgb = BRD_RGB;
        end else begin
            pix_rgb = BG_RGB;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r         <= '0;
            g         <= '0;
            b         <= '0;
            out_valid <= 1'b0;
            hit_any   <= 1'b0;
            hit_idx   <= '0;
        end else begin
            out_valid <= valid_s1;
            if (valid_s1) begin
                r       <= pix_rgb[11:8];
                g       <= pix_rgb[7:4];
                b       <= pix_rgb[3:0];
                hit_any <= win_any;
                hit_idx <= win_idx;
            end else begin
                r       <= '0;
                g       <= '0;
                b       <= '0;
                hit_any <= 1'b0;
                hit_idx <= '0;
            end
        end
    end

    // Clearing the lowest set bit leaves something only when two or more bits are set.
    always_comb begin
        multi_hit = valid_s1 && (|(hit_s1 & (hit_s1 - NUM_SPR'(1))));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            coll_acc <= 1'b0;
            collide  <= 1'b0;
        end else if (frame_start) begin
            collide  <= coll_acc | multi_hit;
            coll_acc <= 1'b0;
        end else begin
            coll_acc <= coll_acc | multi_hit;
        end
    end

endmodule

// File: tb/tb_sprite_compositor.sv
// Randomised and directed checks of sprite_compositor against a per-pixel geometric reference model.
module tb_sprite_compositor;

    localparam int NSPR = 4;
    localparam int IW   = 2;

    logic          clk = 1'b0;
    logic          rst, pix_valid, frame_start, wr_en, wr_vis;
    logic [10:0]   draw_x, wr_x;
    logic [9:0]    draw_y, wr_y;
    logic [IW-1:0] wr_idx;
    logic [11:0]   wr_rgb;
    logic [3:0]    r, g, b;
    logic          out_valid, hit_any, collide;
    logic [IW-1:0] hit_idx;

    always #5 clk = ~clk;

    sprite_compositor #(.NUM_SPR(NSPR), .IDXW(IW)) dut (
        .clk(clk), .rst(rst), .draw_x(draw_x), .draw_y(draw_y),
        .pix_valid(pix_valid), .frame_start(frame_start),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y),
        .wr_rgb(wr_rgb), .wr_vis(wr_vis),
        .r(r), .g(g), .b(b), .out_valid(out_valid),
        .hit_any(hit_any), .hit_idx(hit_idx), .collide(collide)
    );

    typedef struct {
        int x;
        int y;
        int rgb;
        bit vis;
    } spr_t;

    spr_t        pend [NSPR];
    spr_t        act  [NSPR];
    logic [15:0] expq [$];
    bit          acc_m;
    bit          collide_m;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
        end
    endtask

    // Expected {out_valid, hit_any, hit_idx, rgb} for one pixel, plus the number of covering sprites.
    task automatic model_pix(input bit v, input int x, input int y, output logic [15:0] e, output int n);
        int win;
        int c;
        n   = 0;
        win = -1;
        for (int i = 0; i < NSPR; i++) begin
            if (act[i].vis && x >= act[i].x && x < act[i].x + 32 && y >= act[i].y && y < act[i].y + 32) begin
                n++;
                if (win < 0) win = i;
            end
        end
        if (win >= 0) c = act[win].rgb;
        else if (x < 11 || x >= 1269 || y < 11 || y >= 789) c = 'hFFF;
        else c = 'h060;
        if (!v) e = '0;
        else e = {1'b1, (win >= 0), IW'((win >= 0) ? win : 0), 12'(c)};
    endtask

    task automatic step(input bit v, input int x, input int y, input bit fs,
                        input bit we, input int widx, input int wx, input int wy,
                        input int wrgb, input bit wvis, input bit rs);
        logic [15:0] e;
        int          n;
        @(negedge clk);
        if (expq.size() == 2)
            check("pix", 32'({out_valid, hit_any, hit_idx, r, g, b}), 32'(expq.pop_front()));
        pix_valid   = v;
        draw_x      = 11'(x);
        draw_y      = 10'(y);
        frame_start = fs;
        wr_en       = we;
        wr_idx      = IW'(widx);
        wr_x        = 11'(wx);
        wr_y        = 10'(wy);
        wr_rgb      = 12'(wrgb);
        wr_vis      = wvis;
        rst         = rs;
        model_pix(v, x, y, e, n);
        expq.push_back(e);
        if (rs) begin
            foreach (expq[i]) expq[i] = '0;
            for (int i = 0; i < NSPR; i++) begin
                pend[i] = '{0, 0, 0, 1'b0};
                act[i]  = '{0, 0, 0, 1'b0};
            end
            acc_m     = 1'b0;
            collide_m = 1'b0;
        end else begin
            if (fs) begin
                collide_m = acc_m;
                acc_m     = 1'b0;
                act       = pend;
            end
            if (v && n >= 2) acc_m = 1'b1;
            if (we && widx < NSPR) pend[widx] = '{wx, wy, wrgb, wvis};
        end
    endtask

    task automatic pix(input int x, input int y);
        step(1'b1, x, y, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 0, 0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic wr(input int idx, input int x, input int y, input int rgb, input bit vis);
        step(1'b0, 0, 0, 1'b0, 1'b1, idx, x, y, rgb, vis, 1'b0);
    endtask

    task automatic fstart(input bit we, input int idx, input int x, input int y, input int rgb, input bit vis);
        idle();
        idle();
        step(1'b0, 0, 0, 1'b1, we, idx, x, y, rgb, vis, 1'b0);
        idle();
        check("collide", 32'(collide), 32'(collide_m));
    endtask

    task automatic near_pix(input int s);
        int x;
        int y;
        x = act[s].x + $urandom_range(37) - 4;
        y = act[s].y + $urandom_range(37) - 4;
        if (x < 0) x = 0;
        if (x > 1279) x = 1279;
        if (y < 0) y = 0;
        if (y > 799) y = 799;
        pix(x, y);
    endtask

    initial begin
        int xs [8];
        int ys [8];
        xs = '{0, 10, 11, 640, 1268, 1269, 1279, 300};
        ys = '{0, 10, 11, 400, 788, 789, 799, 120};
        rst = 1'b1; pix_valid = 1'b0; frame_start = 1'b0; wr_en = 1'b0;
        draw_x = '0; draw_y = '0; wr_idx = '0; wr_x = '0; wr_y = '0; wr_rgb = '0; wr_vis = 1'b0;
        for (int i = 0; i < NSPR; i++) begin
            pend[i] = '{0, 0, 0, 1'b0};
            act[i]  = '{0, 0, 0, 1'b0};
        end
        acc_m = 1'b0; collide_m = 1'b0;

        repeat (3) step(1'b1, 5, 5, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b1);
        idle();
        check("rst_out", 32'({out_valid, hit_any, hit_idx, r, g, b}), 32'h0);
        check("rst_collide", 32'(collide), 32'h0);

        // Border/background grid with no sprites, interleaved with blanking cycles.
        fstart(1'b0, 0, 0, 0, 0, 1'b0);
        foreach (xs[i]) foreach (ys[j]) begin
            pix(xs[i], ys[j]);
            if ($urandom_range(3) == 0) idle();
        end

        // Single sprite with inclusive bounds.
        wr(0, 100, 200, 'hA22, 1'b1);
        fstart(1'b0, 0, 0, 0, 0, 1'b0);
        pix(100, 200); pix(131, 231); pix(99, 200); pix(132, 200);
        pix(131, 232); pix(100, 199); pix(115, 215);

        // Overlap: priority, then collision reported the following frame.
        wr(0, 100, 100, 'hF00, 1'b1);
        wr(1, 116, 116, 'h00F, 1'b1);
        fstart(1'b0, 0, 0, 0, 0, 1'b0);
        pix(120, 120); pix(140, 140); pix(116, 116); pix(147, 147); pix(148, 148);
        fstart(1'b0, 0, 0, 0, 0, 1'b0);
        fstart(1'b0, 0, 0, 0, 0, 1'b0);

        // Mid-frame write deferred, then a write coincident with frame_start deferred one more frame.
        wr(1, 0, 0, 0, 1'b0);
        wr(0, 300, 300, 'h5A5, 1'b1);
        fstart(1'b0, 0, 0, 0, 0, 1'b0);
        pix(300, 300);
        wr(0, 500, 300, 'h5A5, 1'b1);
        pix(300, 300); pix(500, 300);
        fstart(1'b0, 0, 0, 0, 0, 1'b0);
        pix(300, 300); pix(500, 300);
        fstart(1'b1, 0, 700, 300, 'h5A5, 1'b1);
        pix(500, 300); pix(700, 300);
        fstart(1'b0, 0, 0, 0, 0, 1'b0);
        pix(500, 300); pix(700, 300);

        // Bottom-right corner sprite must not wrap to column 0 or row 0.
        wr(2, 1270, 790, 'h3C7, 1'b1);
        fstart(1'b0, 0, 0, 0, 0, 1'b0);
        for (int x = 1268; x < 1280; x++) pix(x, 795);
        for (int y = 788; y < 800; y++) pix(1275, y);
        pix(0, 790); pix(1270, 0); pix(5, 5); pix(1279, 799);

        // Randomised frames: random attributes, pixels clustered around sprites.
        for (int f = 0; f < 25; f++) begin
            for (int k = 0; k < 3; k++)
                wr($urandom_range(NSPR - 1), $urandom_range(1279), $urandom_range(799),
                   $urandom_range(4095), ($urandom_range(4) != 0));
            if (f % 4 == 0) begin
                wr(1, act[0].x + $urandom_range(40) - 20 + 20, act[0].y + 10, 'h0F0, 1'b1);
                wr(0, act[0].x, act[0].y, 'hF0F, 1'b1);
            end
            if ($urandom_range(1) == 1)
                fstart(1'b1, $urandom_range(NSPR - 1), $urandom_range(1279), $urandom_range(799),
                       $urandom_range(4095), 1'b1);
            else
                fstart(1'b0, 0, 0, 0, 0, 1'b0);
            for (int k = 0; k < 120; k++) begin
                if ($urandom_range(5) == 0) idle();
                else if ($urandom_range(3) == 0) pix($urandom_range(1279), $urandom_range(799));
                else near_pix($urandom_range(NSPR - 1));
                if ($urandom_range(30) == 0)
                    wr($urandom_range(NSPR - 1), $urandom_range(1279), $urandom_range(799),
                       $urandom_range(4095), 1'b1);
            end
        end

        // Reset mid-frame with sprites visible and a collision pending.
        wr(0, 400, 400, 'hF00, 1'b1);
        wr(1, 410, 410, 'h00F, 1'b1);
        fstart(1'b0, 0, 0, 0, 0, 1'b0);
        pix(415, 415);
        fstart(1'b0, 0, 0, 0, 0, 1'b0);
        pix(415, 415); pix(401, 401);
        step(1'b1, 402, 402, 1'b1, 1'b1, 0, 600, 600, 'hFFF, 1'b1, 1'b1);
        pix(415, 415);
        check("rst_mid_collide", 32'(collide), 32'h0);
        pix(401, 401); pix(600, 600); pix(0, 0);
        fstart(1'b0, 0, 0, 0, 0, 1'b0);
        pix(415, 415); pix(600, 600); pix(1279, 799);

        idle(); idle(); idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
- Parametrised successor to the single-block draw controller.
- Composites up to NUM_SPR rectangular solid-colour sprites over a bordered background for the VGA pixel stream.
- Sprite attributes are written through a simple write port into a pending bank, which is copied to the active bank on frame start, so updates never tear mid-frame.
- The output is pipelined with fixed latency, and a per-frame sprite collision flag is produced.

Parameters:
- NUM_SPR, 4, number of sprites (1..16); index 0 has highest priority.
- IDXW, 2, width of the sprite index (>= clog2(NUM_SPR), min 1).
- SPR_W, 32, sprite width in pixels.
- SPR_H, 32, sprite height in pixels.
- SCR_W, 1280, active width.
- SCR_H, 800, active height.
- BORDER, 11, border thickness in pixels on all four edges.
- BG_RGB, 12'h060, background colour {r,g,b}.
- BRD_RGB, 12'hFFF, border colour.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous active-high reset.
- draw_x  in  11  current pixel column.
- draw_y  in  10  current pixel row.
- pix_valid  in  1  draw_x/draw_y lie in the active area this cycle.
- frame_start  in  1  one-cycle pulse before pixel (0,0) of each frame.
- wr_en  in  1  attribute write strobe.
- wr_idx  in  IDXW  target sprite.
- wr_x  in  11  sprite left column.
- wr_y  in  10  sprite top row.
- wr_rgb  in  12  sprite colour {r,g,b}.
- wr_vis  in  1  sprite visible.
- r  out  4  red.
- g  out  4  green.
- b  out  4  blue.
- out_valid  out  1  pix_valid delayed to align with r/g/b.
- hit_any  out  1  some visible sprite covers the output pixel.
- hit_idx  out  IDXW  winning sprite index (0 when hit_any=0).
- collide  out  1  previous frame had at least one pixel covered by 2+ visible sprites.

Behaviour:
Reset:
- Synchronous, active-high on the clk edge.
- Clears both banks: all pos=0, rgb=0, vis=0.
- Clears pipeline registers, r/g/b=0, out_valid=0, hit_any=0, hit_idx=0, collide=0, internal collision accumulator=0.
- rst asserted mid-frame takes effect at the next edge and overrides wr_en and frame_start in that cycle.

Write port:
- wr_en=1 with wr_idx<NUM_SPR updates pending[wr_idx] at the clock edge.
- wr_idx>=NUM_SPR is ignored.
- No ready/back-pressure; one write per cycle.

Bank transfer:
- On a frame_start cycle, active <= pending (all sprites at once).
- If wr_en and frame_start coincide, the transfer uses pending contents before the write; the new write is visible from the following frame.

Hit test (stage 1):
- Sprite i hits when vis=1, pos_x <= draw_x <= pos_x+SPR_W-1 and pos_y <= draw_y <= pos_y+SPR_H-1.
- Both bounds are inclusive.
- The sums are computed 1 bit wider (12/11 bits) so sprites near the right or bottom edge never wrap. For example, pos_x=1270 covers columns 1270..1279 on screen and nothing at column 0.
- Border test: draw_x<BORDER, draw_x>=SCR_W-BORDER, draw_y<BORDER, or draw_y>=SCR_H-BORDER.
- Stage 1 registers: hit vector, border flag, pix_valid.

Priority and colour (stage 2):
- Lowest set index wins and its rgb drives r/g/b.
- With no hit, the border flag selects BRD_RGB, otherwise BG_RGB.
- Sprites draw over the border.
- If the stage-1 pix_valid=0, r/g/b=0 (blanking) and hit_any=0.

Latency:
- Exactly 2 cycles from draw_x/draw_y/pix_valid to r/g/b/out_valid/hit_any/hit_idx.
- Pipeline uses no stalls.

Collision:
- Internal flag is set when the stage-1 pix_valid=1 and popcount(hit vector)>=2.
- On frame_start: collide <= internal flag (OR any collision in that same cycle), then internal flag <= 0.
- collide holds its value for the whole following frame.

Test Plan:
- Reset, no writes, scan full frame -> border pixels (x=0..10, 1269..1279, y=0..10, 789..799) = F/F/F; interior (640,400) = 0/6/0; out_valid follows pix_valid by 2 cycles.
- Write idx0 x=100 y=200 rgb=A22 vis=1, pulse frame_start -> (100,200) and (131,231) give A/2/2 with hit_idx=0; (99,200) and (132,200) give background.
- Overlap: idx0 at (100,100) rgb=F00, idx1 at (116,116) rgb=00F -> (120,120) = F/0/0; (140,140) = 0/0/F with hit_idx=1; next frame collide=1.
- Write mid-frame (idx0 x=500) -> current frame keeps old position; after next frame_start the sprite appears at x=500. Write coincident with frame_start is deferred one frame.
- Edge: idx2 x=1270 y=790 -> columns 1270..1279, rows 790..799 are sprite coloured; (0,790) and (1270,0) are not sprite coloured, with no wrap.
- rst asserted mid-frame with sprites visible -> next cycle outputs 0, collide=0; after release the screen shows only border/background until new writes and frame_start.
